simd_mem_writeback: RTL
=======================

Name: simd_mem_writeback

Overview:
- Parametrised memory-access and writeback stage for the SIMD pipeline, sitting between execute and the vector register file.
- Accepts one vector transaction per cycle under a valid/ready handshake. Performs a lane-masked store or a synchronous load against an internal element-addressed data memory.
- Selects the writeback source: memory, ALU, or broadcast immediate. Presents the result one cycle later, with per-lane register write enables and back-pressure support.

Parameters:
- VEC_SIZE, 4, number of lanes.
- REG_SIZE, 16, bits per lane register and immediate.
- MEM_DATA, 8, bits per memory element (MEM_DATA <= REG_SIZE).
- MEM_DEPTH, 256, number of memory elements (power of two).
- RD_BITS, 4, destination register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  transaction present.
- in_ready  out  1  stage can accept.
- in_op  in  2  00 LOAD, 01 ALU, 10 IMM, 11 STORE.
- in_addr_sel  in  1  1: base address = in_operand2[0]; 0: base address = in_imm.
- in_load_signed  in  1  LOAD sign-extends when 1, zero-extends when 0.
- in_lane_mask  in  VEC_SIZE  per-lane enable.
- in_rd  in  RD_BITS  destination register.
- in_imm  in  REG_SIZE  immediate.
- in_alu_result  in  VEC_SIZE*REG_SIZE  ALU result vector.
- in_operand1  in  VEC_SIZE*REG_SIZE  store data vector.
- in_operand2  in  VEC_SIZE*REG_SIZE  address operand vector.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_we  out  1  register write (0 for STORE).
- out_lane_we  out  VEC_SIZE  per-lane write enable.
- out_rd  out  RD_BITS  destination register.
- out_data  out  VEC_SIZE*REG_SIZE  writeback vector.

Behaviour:
- **Clock and reset:** single clk domain. Reset is synchronous and active-high and has priority over everything else.
- **Reset values:** out_valid=0, out_we=0, out_lane_we=0, out_rd=0, out_data=0, in_ready=0 while reset is high. Memory contents are not cleared.
- **Reset mid-operation:** a pending S2 result is dropped. A STORE presented in a reset cycle does not write.
- **Accept:** fire = in_valid & in_ready. in_ready = !out_valid | out_ready (skid-less, single output register).
- **Addressing:** base = selected address source mod MEM_DEPTH. Lane i uses element (base+i) mod MEM_DEPTH, so wrap-around past the top of memory is legal.
- **STORE on fire:** at the clock edge, mem[(base+i)] <= in_operand1[i][MEM_DATA-1:0] for each lane with in_lane_mask[i]=1. Unmasked lanes leave memory unchanged.
- **LOAD on fire:** each lane reads its element synchronously and the read data register is captured at the edge. The read register updates only on fire, so data is held stable while stalled.
- **Read-after-write ordering:** a STORE followed by a LOAD in the next accepted cycle returns the newly stored data.
- **Latency:** exactly 1 cycle. A transaction fired at edge N appears with out_valid=1 after edge N. The output holds unchanged while out_valid & !out_ready.
- **Output register update:** when out_ready=1 and no fire, out_valid clears. Simultaneous consume and fire loads the new transaction, giving full throughput of 1 per cycle.
- **out_data by op:**
  - LOAD: lane = extend(read element) to REG_SIZE, sign- or zero-extended per in_load_signed. Masked-off lanes output 0.
  - ALU: in_alu_result, unmodified.
  - IMM: in_imm replicated to every lane.
  - STORE: 0.
- **Write enables:** out_we = (op != STORE). out_lane_we = in_lane_mask for LOAD, ALU and IMM; 0 for STORE. out_rd is registered from in_rd.
- **Registered fields:** all S2 fields (op, signed flag, mask, rd, alu, imm) are registered on fire only.

Test Plan:
- **Reset:** assert reset 2 cycles with in_valid=1, in_op=STORE, mask=1111 -> outputs all 0, in_ready=0. A later LOAD of that address returns the pre-reset memory value.
- **Store then load:** STORE base=imm=0x0010, operand1 lanes {0x11AA,0x22BB,0x33CC,0x44DD}, mask=1111. Next cycle LOAD imm=0x0010 unsigned -> one cycle later out_data={0x00AA,0x00BB,0x00CC,0x00DD}, out_lane_we=1111, out_we=1.
- **Masked store, signed load, wrap-around:** STORE base=operand2[0]=0x00FE, mask=0101, data lane0=0x0080, lane2=0x007F. LOAD signed base 0x00FE -> lane0=0xFF80 (element 254), lane2=0x007F (element 0). Lanes 1 and 3 hold prior contents.
- **Back-pressure:** issue ALU {1,2,3,4} then IMM 0x1234 with out_ready=0 for 3 cycles -> in_ready=0 after the first fire, out_data stays {1,2,3,4}. Raise out_ready -> IMM result {0x1234 x4} appears the next cycle with no loss or duplication.
- **Throughput:** 8 back-to-back ALU ops with out_ready=1 -> 8 consecutive out_valid cycles, in order, out_rd matching in_rd.
- **Store passes through:** STORE -> out_valid=1, out_we=0, out_lane_we=0000, out_data=0.

Source files
------------

// File: rtl/simd_mem_writeback.sv
// Memory-access and writeback stage for the SIMD pipeline: lane-masked store or synchronous
// load against an element-addressed memory, then a single registered writeback slot.
module simd_mem_writeback #(
  parameter int VEC_SIZE  = 4,
  parameter int REG_SIZE  = 16,
  parameter int MEM_DATA  = 8,
  parameter int MEM_DEPTH = 256,
  parameter int RD_BITS   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic                         in_addr_sel,
  input  logic                         in_load_signed,
  input  logic [VEC_SIZE-1:0]          in_lane_mask,
  input  logic [RD_BITS-1:0]           in_rd,
  input  logic [REG_SIZE-1:0]          in_imm,
  input  logic [VEC_SIZE*REG_SIZE-1:0] in_alu_result,
  input  logic [VEC_SIZE*REG_SIZE-1:0] in_operand1,
  input  logic [VEC_SIZE*REG_SIZE-1:0] in_operand2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_we,
  output logic [VEC_SIZE-1:0]          out_lane_we,
  output logic [RD_BITS-1:0]           out_rd,
  output logic [VEC_SIZE*REG_SIZE-1:0] out_data
);

  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ALU   = 2'b01,
    OP_IMM   = 2'b10,
    OP_STORE = 2'b11
  } op_e;

  logic                         fire;
  op_e                          in_op_e;
  logic [AW-1:0]                base_addr;
  logic [AW-1:0]                lane_addr [VEC_SIZE];
  logic [VEC_SIZE-1:0]          mem_we;
  logic [MEM_DATA-1:0]          mem_wdata [VEC_SIZE];
  logic [MEM_DATA-1:0]          mem_q [MEM_DEPTH];

  logic                         valid_q, valid_d;
  op_e                          op_q, op_d;
  logic                         sgn_q, sgn_d;
  logic [VEC_SIZE-1:0]          mask_q, mask_d;
  logic [RD_BITS-1:0]           rd_q, rd_d;
  logic [VEC_SIZE*REG_SIZE-1:0] alu_q, alu_d;
  logic [REG_SIZE-1:0]          imm_q, imm_d;
  logic [MEM_DATA-1:0]          rdata_q [VEC_SIZE];
  logic [MEM_DATA-1:0]          rdata_d [VEC_SIZE];

  logic                         unused_bits;

  assign unused_bits = ^{in_operand1, in_operand2};

  function automatic logic [REG_SIZE-1:0] extend(input logic [MEM_DATA-1:0] elem,
                                                 input logic sgn);
    logic [REG_SIZE-1:0] r;
    r = '0;
    r[MEM_DATA-1:0] = elem;
    if (sgn && elem[MEM_DATA-1]) begin
      for (int b = MEM_DATA; b < REG_SIZE; b++) begin
        r[b] = 1'b1;
      end
    end
    return r;
  endfunction

  // Single output register: accept whenever the slot is empty or being drained this cycle.
  assign in_ready = !reset && (!valid_q || out_ready);
  assign fire     = in_valid && in_ready;
  assign in_op_e  = op_e'(in_op);

  always_comb begin
    base_addr = in_addr_sel ? in_operand2[AW-1:0] : in_imm[AW-1:0];
    for (int i = 0; i < VEC_SIZE; i++) begin
      lane_addr[i] = base_addr + AW'(i);
      mem_we[i]    = fire && (in_op_e == OP_STORE) && in_lane_mask[i];
      mem_wdata[i] = in_operand1[i*REG_SIZE +: MEM_DATA];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < VEC_SIZE; i++) begin
      if (mem_we[i]) begin
        mem_q[lane_addr[i]] <= mem_wdata[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    mask_d  = mask_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    imm_d   = imm_q;
    for (int i = 0; i < VEC_SIZE; i++) begin
      rdata_d[i] = rdata_q[i];
    end
    if (fire) begin
      valid_d = 1'b1;
      op_d    = in_op_e;
      sgn_d   = in_load_signed;
      mask_d  = in_lane_mask;
      rd_d    = in_rd;
      alu_d   = in_alu_result;
      imm_d   = in_imm;
      for (int i = 0; i < VEC_SIZE; i++) begin
        rdata_d[i] = mem_q[lane_addr[i]];
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Resetting op to STORE makes every derived output read as zero until the next fire.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= OP_STORE;
      sgn_q   <= 1'b0;
      mask_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      imm_q   <= '0;
      for (int i = 0; i < VEC_SIZE; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      imm_q   <= imm_d;
      for (int i = 0; i < VEC_SIZE; i++) begin
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  always_comb begin
    out_valid   = valid_q;
    out_we      = (op_q != OP_STORE);
    out_lane_we = (op_q == OP_STORE) ? '0 : mask_q;
    out_rd      = rd_q;
    out_data    = '0;
    case (op_q)
      OP_LOAD: begin
        for (int i = 0; i < VEC_SIZE; i++) begin
          out_data[i*REG_SIZE +: REG_SIZE] =
            mask_q[i] ? extend(rdata_q[i], sgn_q) : '0;
        end
      end
      OP_ALU: out_data = alu_q;
      OP_IMM: out_data = {VEC_SIZE{imm_q}};
      default: out_data = '0;
    endcase
  end

endmodule
